rv32i_mem_arbiter: RTL and testbench

Shares the single word-wide memory bus between instruction fetch and the load/store unit. Data requests have priority, with a starvation guard for fetch. The block also does all lane handling for RV32I loads and stores: byte enables, store-data replication, and load extraction with sign or zero extension, all keyed on load_t/store_t funct3. It sits between the fetch/execute stages and the memory/cache port.

---
 rtl/rv32i_types_pkg.sv | 48 ++++
 rtl/mem_lane_align.sv | 58 +++++
 rtl/rv32i_mem_arbiter.sv | 174 +++++++++++++++++
 tb/tb_rv32i_mem_arbiter.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_types_pkg.sv
// ----------------------------------------------------------------------------
// rv32i_types_pkg
// Shared RV32I type definitions used by the memory arbiter and its lane logic.
//   load_t      : funct3 encodings of the RV32I load instructions
//   store_t     : funct3 encodings of the RV32I store instructions
//   arb_state_t : memory-bus arbiter FSM states
//   D_STREAK_W  : width of the consecutive-data-grant counter
//   access_size_log2() : log2 of the access size in bytes for a funct3
// Optional build macro used by the arbiter: MEM_ARB_MISALIGN_CHECK_EN.
// ----------------------------------------------------------------------------
package rv32i_types_pkg;

    typedef enum logic [2:0] {
        LB  = 3'b000,
        LH  = 3'b001,
        LW  = 3'b010,
        LBU = 3'b100,
        LHU = 3'b101
    } load_t;

    typedef enum logic [2:0] {
        SB = 3'b000,
        SH = 3'b001,
        SW = 3'b010
    } store_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_I = 2'd1,
        GRANT_D = 2'd2
    } arb_state_t;

    // Streak counter width; holds MAX_D_STREAK values up to 15.
    localparam int D_STREAK_W = 4;

    // Size from funct3[1:0]: 00 byte, 01 half, anything else word.
    // Unused encodings (011, 110, 111) therefore behave as word accesses.
    function automatic logic [1:0] access_size_log2(input logic [2:0] funct3);
        logic [1:0] size;
        case (funct3[1:0])
            2'b00:   size = 2'd0;
            2'b01:   size = 2'd1;
            default: size = 2'd2;
        endcase
        return size;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// ----------------------------------------------------------------------------
// mem_lane_align
// Purely combinational RV32I byte-lane handling for the data port.
// Ports:
//   i_funct3  : load_t/store_t funct3 of the access
//   i_lane    : byte offset within the word (address bits [1:0])
//   i_wdata   : right-justified store data
//   i_rdata   : raw bus read word
//   o_byte_en : byte lane enables (shared by loads and stores)
//   o_wdata   : store data replicated across the lanes
//   o_rdata   : load data shifted down and sign/zero extended
// ----------------------------------------------------------------------------
module mem_lane_align
    import rv32i_types_pkg::*;
(
    input  logic [2:0]  i_funct3,
    input  logic [1:0]  i_lane,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rdata,
    output logic [3:0]  o_byte_en,
    output logic [31:0] o_wdata,
    output logic [31:0] o_rdata
);

    logic [31:0] w_shifted;

    always_comb begin
        o_byte_en = 4'b1111;
        o_wdata   = i_wdata;
        o_rdata   = '0;
        w_shifted = i_rdata >> {i_lane, 3'b000};

        // A half at lane 3 keeps only its low byte enable (shift truncates).
        case (access_size_log2(i_funct3))
            2'd0: begin
                o_byte_en = 4'b0001 << i_lane;
                o_wdata   = {4{i_wdata[7:0]}};
            end
            2'd1: begin
                o_byte_en = 4'b0011 << i_lane;
                o_wdata   = {2{i_wdata[15:0]}};
            end
            default: begin
                o_byte_en = 4'b1111;
                o_wdata   = i_wdata;
            end
        endcase

        case (i_funct3)
            LB:      o_rdata = {{24{w_shifted[7]}}, w_shifted[7:0]};
            LBU:     o_rdata = {24'd0, w_shifted[7:0]};
            LH:      o_rdata = {{16{w_shifted[15]}}, w_shifted[15:0]};
            LHU:     o_rdata = {16'd0, w_shifted[15:0]};
            default: o_rdata = w_shifted;
        endcase
    end

endmodule

// File: rtl/rv32i_mem_arbiter.sv
// ----------------------------------------------------------------------------
// rv32i_mem_arbiter
// Shares one word-wide memory bus between instruction fetch (i_*) and the
// load/store unit (d_*). Data wins arbitration unless it has already taken
// MAX_D_STREAK grants in a row while fetch waited; then fetch is forced in.
// Ports:
//   CLK, nRST              : clock, asynchronous active-low reset
//   i_ren/i_addr           : fetch request; i_rdata/i_busy back to fetch
//   d_ren/d_wen/d_funct3/d_addr/d_wdata : load/store request
//   d_rdata/d_busy         : extended load data and data stall
//   d_misaligned           : misaligned data request flag
//   m_ren/m_wen/m_addr/m_wdata/m_byte_en : bus command
//   m_rdata/m_busy         : bus response (m_busy=0 completes the access)
//   o_dbg_state            : current arb_state_t (debug)
//   o_dbg_streak           : current consecutive-data-grant count (debug)
// Build macro: MEM_ARB_MISALIGN_CHECK_EN enables misaligned-request rejection
// in IDLE; when undefined d_misaligned is tied 0.
//
// Handshake: a requester raises its ren/wen and holds it (with stable
// address/data) until it sees its busy low; the cycle busy is low while the
// request is high is the completion cycle and carries the read data. Busy is
// never asserted without a request. On the bus side the command is held while
// m_busy=1 and completes in the first cycle m_busy=0.
// ----------------------------------------------------------------------------
module rv32i_mem_arbiter
    import rv32i_types_pkg::*;
#(
    parameter int MAX_D_STREAK = 4
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        i_ren,
    input  logic [31:0] i_addr,
    output logic [31:0] i_rdata,
    output logic        i_busy,
    input  logic        d_ren,
    input  logic        d_wen,
    input  logic [2:0]  d_funct3,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_busy,
    output logic        d_misaligned,
    output logic        m_ren,
    output logic        m_wen,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    output logic [3:0]  m_byte_en,
    input  logic [31:0] m_rdata,
    input  logic        m_busy,
    output logic [1:0]  o_dbg_state,
    output logic [3:0]  o_dbg_streak
);

    localparam logic [D_STREAK_W-1:0] MAX_STREAK = D_STREAK_W'(MAX_D_STREAK);

    arb_state_t              r_state;
    arb_state_t              w_next_state;
    logic [D_STREAK_W-1:0]   r_d_streak;

    logic        w_d_req;
    logic        w_d_arb;
    logic        w_misaligned;
    logic        w_i_done;
    logic        w_d_done;
    logic [3:0]  w_lane_be;
    logic [31:0] w_lane_wdata;
    logic [31:0] w_lane_rdata;
    logic        w_unused;

    // Fetch addresses are word aligned; the low bits carry no information.
    assign w_unused = &{1'b0, i_addr[1:0]};

    assign w_d_req = d_ren | d_wen;

`ifdef MEM_ARB_MISALIGN_CHECK_EN
    // Only judged in IDLE: a flagged request completes there without a grant.
    assign w_misaligned = (r_state == IDLE) && w_d_req &&
                          (((d_funct3[1:0] == 2'b01) && d_addr[0]) ||
                           ((d_funct3 == 3'b010) && (d_addr[1:0] != 2'b00)));
`else
    assign w_misaligned = 1'b0;
`endif

    // A rejected (misaligned) data request does not compete for the bus.
    assign w_d_arb = w_d_req & ~w_misaligned;

    mem_lane_align u_lane (
        .i_funct3  (d_funct3),
        .i_lane    (d_addr[1:0]),
        .i_wdata   (d_wdata),
        .i_rdata   (m_rdata),
        .o_byte_en (w_lane_be),
        .o_wdata   (w_lane_wdata),
        .o_rdata   (w_lane_rdata)
    );

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        m_ren        = 1'b0;
        m_wen        = 1'b0;
        m_addr       = '0;
        m_wdata      = '0;
        m_byte_en    = '0;
        i_rdata      = '0;
        d_rdata      = '0;
        w_i_done     = 1'b0;
        w_d_done     = 1'b0;

        case (r_state)
            IDLE: begin
                if (w_d_arb && i_ren) begin
                    w_next_state = (r_d_streak == MAX_STREAK) ? GRANT_I : GRANT_D;
                end else if (w_d_arb) begin
                    w_next_state = GRANT_D;
                end else if (i_ren) begin
                    w_next_state = GRANT_I;
                end
            end
            GRANT_I: begin
                m_ren     = 1'b1;
                m_addr    = {i_addr[31:2], 2'b00};
                m_byte_en = 4'b1111;
                if (!m_busy) begin
                    w_i_done     = 1'b1;
                    i_rdata      = m_rdata;
                    w_next_state = IDLE;
                end
            end
            GRANT_D: begin
                // A store wins if both ren and wen are (illegally) set.
                m_ren     = d_ren & ~d_wen;
                m_wen     = d_wen;
                m_addr    = {d_addr[31:2], 2'b00};
                m_byte_en = w_lane_be;
                m_wdata   = w_lane_wdata;
                if (!m_busy) begin
                    w_d_done     = 1'b1;
                    d_rdata      = w_lane_rdata;
                    w_next_state = IDLE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Streak counts data completions only while fetch is actually waiting.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_d_streak <= '0;
        end else if (!i_ren || w_i_done) begin
            r_d_streak <= '0;
        end else if (w_d_done && (r_d_streak != MAX_STREAK)) begin
            r_d_streak <= r_d_streak + 1'b1;
        end
    end

    assign i_busy       = i_ren & ~w_i_done;
    assign d_busy       = w_d_req & ~w_d_done & ~w_misaligned;
    assign d_misaligned = w_misaligned;
    assign o_dbg_state  = r_state;
    assign o_dbg_streak = r_d_streak;

endmodule

// File: tb/tb_rv32i_mem_arbiter.sv
// ----------------------------------------------------------------------------
// tb_rv32i_mem_arbiter
// Directed and randomized stimulus for rv32i_mem_arbiter. Expected lane
// behaviour comes from a byte-by-byte model of RV32I loads/stores; the
// arbitration expectation is "MAX_D_STREAK data grants, then one fetch".
// ----------------------------------------------------------------------------
module tb_rv32i_mem_arbiter;
    import rv32i_types_pkg::*;

    localparam int MAX_D = 4;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        i_ren;
    logic [31:0] i_addr;
    logic [31:0] i_rdata;
    logic        i_busy;
    logic        d_ren;
    logic        d_wen;
    logic [2:0]  d_funct3;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_busy;
    logic        d_misaligned;
    logic        m_ren;
    logic        m_wen;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [3:0]  m_byte_en;
    logic [31:0] m_rdata;
    logic        m_busy;
    logic [1:0]  o_dbg_state;
    logic [3:0]  o_dbg_streak;

    int n_cmp = 0;
    int n_err = 0;

    always #5 CLK = ~CLK;

    rv32i_mem_arbiter #(.MAX_D_STREAK(MAX_D)) dut (
        .CLK          (CLK),
        .nRST         (nRST),
        .i_ren        (i_ren),
        .i_addr       (i_addr),
        .i_rdata      (i_rdata),
        .i_busy       (i_busy),
        .d_ren        (d_ren),
        .d_wen        (d_wen),
        .d_funct3     (d_funct3),
        .d_addr       (d_addr),
        .d_wdata      (d_wdata),
        .d_rdata      (d_rdata),
        .d_busy       (d_busy),
        .d_misaligned (d_misaligned),
        .m_ren        (m_ren),
        .m_wen        (m_wen),
        .m_addr       (m_addr),
        .m_wdata      (m_wdata),
        .m_byte_en    (m_byte_en),
        .m_rdata      (m_rdata),
        .m_busy       (m_busy),
        .o_dbg_state  (o_dbg_state),
        .o_dbg_streak (o_dbg_streak)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // ---------------- reference model ----------------
    function automatic int op_bytes(input logic [2:0] f3);
        if (f3[1:0] == 2'b00) return 1;
        if (f3[1:0] == 2'b01) return 2;
        return 4;
    endfunction

    function automatic logic [3:0] model_be(input logic [2:0] f3, input logic [1:0] a);
        logic [3:0] be;
        int sz;
        sz = op_bytes(f3);
        for (int k = 0; k < 4; k++) be[k] = (k >= int'(a)) && (k < int'(a) + sz);
        return be;
    endfunction

    function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] wd);
        logic [31:0] v;
        int sz;
        sz = op_bytes(f3);
        for (int k = 0; k < 4; k++) v[8*k +: 8] = wd[8*(k % sz) +: 8];
        return v;
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [1:0] a,
                                               input logic [31:0] rd);
        logic [31:0] v;
        int sz;
        sz = op_bytes(f3);
        v  = '0;
        for (int i = 0; i < sz; i++)
            if (int'(a) + i < 4) v[8*i +: 8] = rd[8*(int'(a) + i) +: 8];
        if (!f3[2] && sz < 4 && v[8*sz-1]) v = v | (32'hFFFF_FFFF << (8*sz));
        return v;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic data_txn(input string tag, input bit is_store, input logic [2:0] f3,
                            input logic [31:0] addr, input logic [31:0] wd,
                            input logic [31:0] rd, input int stalls);
        d_ren    = !is_store;
        d_wen    = is_store;
        d_funct3 = f3;
        d_addr   = addr;
        d_wdata  = wd;
        m_busy   = 1'b1;
        m_rdata  = $urandom;
        #1;
        chk({tag, " idle no bus"}, {31'd0, m_ren | m_wen}, 32'd0);
        chk({tag, " idle d_busy"}, {31'd0, d_busy}, 32'd1);
        step();
        for (int s = 0; s <= stalls; s++) begin
            m_busy  = (s < stalls);
            m_rdata = (s < stalls) ? $urandom : rd;
            #1;
            chk({tag, " m_wen"}, {31'd0, m_wen}, {31'd0, is_store});
            chk({tag, " m_ren"}, {31'd0, m_ren}, {31'd0, !is_store});
            chk({tag, " m_addr"}, m_addr, {addr[31:2], 2'b00});
            chk({tag, " m_byte_en"}, {28'd0, m_byte_en}, {28'd0, model_be(f3, addr[1:0])});
            chk({tag, " d_busy"}, {31'd0, d_busy}, {31'd0, s < stalls});
            if (is_store) chk({tag, " m_wdata"}, m_wdata, model_wdata(f3, wd));
            if (!is_store && s == stalls) chk({tag, " d_rdata"}, d_rdata, model_load(f3, addr[1:0], rd));
            step();
        end
        d_ren  = 1'b0;
        d_wen  = 1'b0;
        m_busy = 1'b0;
        #1;
        chk({tag, " bubble"}, {31'd0, m_ren | m_wen}, 32'd0);
        chk({tag, " bubble state"}, {30'd0, o_dbg_state}, {30'd0, IDLE});
    endtask

    task automatic fetch_txn(input string tag, input logic [31:0] addr,
                             input logic [31:0] rd, input int stalls);
        i_ren   = 1'b1;
        i_addr  = addr;
        m_busy  = 1'b1;
        m_rdata = $urandom;
        #1;
        chk({tag, " idle m_ren"}, {31'd0, m_ren}, 32'd0);
        chk({tag, " idle i_busy"}, {31'd0, i_busy}, 32'd1);
        step();
        for (int s = 0; s <= stalls; s++) begin
            m_busy  = (s < stalls);
            m_rdata = (s < stalls) ? $urandom : rd;
            #1;
            chk({tag, " m_ren"}, {31'd0, m_ren}, 32'd1);
            chk({tag, " m_addr"}, m_addr, addr);
            chk({tag, " m_byte_en"}, {28'd0, m_byte_en}, 32'hF);
            chk({tag, " i_busy"}, {31'd0, i_busy}, {31'd0, s < stalls});
            if (s == stalls) chk({tag, " i_rdata"}, i_rdata, rd);
            step();
        end
        i_ren  = 1'b0;
        m_busy = 1'b0;
        #1;
        chk({tag, " bubble state"}, {30'd0, o_dbg_state}, {30'd0, IDLE});
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [2:0]  ld_ops [5];
        logic [2:0]  st_ops [3];
        logic [2:0]  f3;
        logic [31:0] rnd;
        logic [31:0] base;
        logic [1:0]  lane;
        int          sz;
        int          d_run;
        int          grants;
        bit          found;

        ld_ops = '{LB, LH, LW, LBU, LHU};
        st_ops = '{SB, SH, SW};

        nRST = 1'b0; i_ren = 1'b0; i_addr = '0; d_ren = 1'b0; d_wen = 1'b0;
        d_funct3 = '0; d_addr = '0; d_wdata = '0; m_rdata = '0; m_busy = 1'b0;
        #2;
        chk("rst m_ren", {31'd0, m_ren}, 32'd0);
        chk("rst m_wen", {31'd0, m_wen}, 32'd0);
        chk("rst m_byte_en", {28'd0, m_byte_en}, 32'd0);
        chk("rst m_addr", m_addr, 32'd0);
        chk("rst m_wdata", m_wdata, 32'd0);
        chk("rst i_rdata", i_rdata, 32'd0);
        chk("rst d_rdata", d_rdata, 32'd0);
        chk("rst d_misaligned", {31'd0, d_misaligned}, 32'd0);
        chk("rst busy", {30'd0, i_busy, d_busy}, 32'd0);
        chk("rst state", {30'd0, o_dbg_state}, {30'd0, IDLE});
        @(negedge CLK);
        nRST = 1'b1;
        step();

        // Directed cases
        fetch_txn("fetch", 32'h100, 32'hDEAD_BEEF, 0);
        data_txn("lb", 1'b0, LB, 32'h203, 32'd0, 32'h80FF_FF7F, 0);
        data_txn("lbu", 1'b0, LBU, 32'h203, 32'd0, 32'h80FF_FF7F, 0);
        data_txn("sh", 1'b1, SH, 32'h302, 32'h1234_ABCD, 32'd0, 0);
        data_txn("lh stall", 1'b0, LH, 32'h602, 32'd0, 32'h8001_1234, 2);
        data_txn("sw funct3 011", 1'b1, 3'b011, 32'h700, 32'hCAFE_F00D, 32'd0, 1);
`ifndef MEM_ARB_MISALIGN_CHECK_EN
        data_txn("sh lane3", 1'b1, SH, 32'h803, 32'h0000_5A3C, 32'd0, 0);
`endif

        // Randomized transactions, naturally aligned
        for (int n = 0; n < 40; n++) begin
            rnd  = $urandom;
            base = rnd & 32'hFFFF_FFFC;
            case ($urandom_range(0, 2))
                0: begin
                    f3 = ld_ops[$urandom_range(0, 4)];
                    sz = op_bytes(f3);
                    lane = (sz == 1) ? 2'($urandom_range(0, 3)) : (sz == 2) ? 2'($urandom_range(0, 1) * 2) : 2'd0;
                    data_txn("rand load", 1'b0, f3, base | {30'd0, lane}, 32'd0, $urandom, $urandom_range(0, 3));
                end
                1: begin
                    f3 = st_ops[$urandom_range(0, 2)];
                    sz = op_bytes(f3);
                    lane = (sz == 1) ? 2'($urandom_range(0, 3)) : (sz == 2) ? 2'($urandom_range(0, 1) * 2) : 2'd0;
                    data_txn("rand store", 1'b1, f3, base | {30'd0, lane}, $urandom, 32'd0, $urandom_range(0, 3));
                end
                default: fetch_txn("rand fetch", base, $urandom, $urandom_range(0, 3));
            endcase
        end

        // Starvation guard: both requesters held, bus never stalls
        i_addr = 32'h1000; d_addr = 32'h2000; d_funct3 = LW;
        i_ren = 1'b1; d_ren = 1'b1; m_busy = 1'b0; m_rdata = $urandom;
        d_run  = 0;
        grants = 0;
        for (int c = 0; c < 30; c++) begin
            #1;
            if (m_ren) begin
                chk("starve fetch grant", {31'd0, m_addr == 32'h1000}, {31'd0, d_run == MAX_D});
                d_run = (m_addr == 32'h1000) ? 0 : d_run + 1;
                grants++;
            end else begin
                chk("starve streak", {28'd0, o_dbg_streak}, 32'(d_run));
            end
            step();
        end
        chk("starve grants", 32'(grants), 32'd15);
        i_ren = 1'b0; d_ren = 1'b0;
        step();

        // Stall then reset in GRANT_D with a non-zero streak
        i_addr = 32'h1000; i_ren = 1'b1;
        d_wen = 1'b1; d_funct3 = SW; d_addr = 32'h500; d_wdata = $urandom; m_busy = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 8 && !found; c++) begin
            #1;
            if (o_dbg_state == GRANT_D && o_dbg_streak == 4'd1) begin
                m_busy = 1'b1;
                found  = 1'b1;
            end else begin
                step();
            end
        end
        chk("stall reached", {31'd0, found}, 32'd1);
        for (int s = 0; s < 3; s++) begin
            #1;
            chk("stall m_wen", {31'd0, m_wen}, 32'd1);
            chk("stall d_busy", {31'd0, d_busy}, 32'd1);
            step();
        end
        #2;
        nRST = 1'b0;
        #1;
        chk("reset m_wen", {31'd0, m_wen}, 32'd0);
        chk("reset state", {30'd0, o_dbg_state}, {30'd0, IDLE});
        chk("reset streak", {28'd0, o_dbg_streak}, 32'd0);
        chk("reset d_busy", {31'd0, d_busy}, 32'd1);
        i_ren = 1'b0; d_wen = 1'b0; m_busy = 1'b0;
        step();
        nRST = 1'b1;
        step();

`ifdef MEM_ARB_MISALIGN_CHECK_EN
        d_ren = 1'b1; d_funct3 = LW; d_addr = 32'h401;
        #1;
        chk("misalign flag", {31'd0, d_misaligned}, 32'd1);
        chk("misalign d_busy", {31'd0, d_busy}, 32'd0);
        chk("misalign m_ren", {31'd0, m_ren}, 32'd0);
        chk("misalign d_rdata", d_rdata, 32'd0);
        d_ren = 1'b0;
        step();
`endif

        // Post-reset sanity: a fresh fetch still works
        fetch_txn("post reset fetch", 32'h0000_0040, 32'h0BAD_F00D, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
